jtag_dr_tx: RTL and testbench
=============================

# jtag_dr_tx

Transmit side of the debug-register JTAG link: the JTAG-to-SoC path receives 32-bit words shifted in on TDI, and this block returns 32-bit words from the SoC to the host on TDO through the ECP5 `JTAGG` `JTDO1`/`JTDO2` inputs. It sits in `top_fpga` next to the existing JTAG DR receiver and is clocked from `clk48m`. It oversamples `JTCK`, loads a one-entry holding register into a shift register at Capture-DR, and shifts the word out LSB-first during Shift-DR.

## Interface
Parameters:
- `CHAIN`, default 1: which `JTAGG` user chain drives this block. 1 means `jce1`, IR 0x32. 2 means `jce2`, IR 0x38.

Ports:
- `clk`  in  1  system clock (`clk48m` in `top_fpga`)
- `rst`  in  1  reset, asynchronous, active-high
- `jtck`  in  1  raw `JTCK` from `JTAGG`; asynchronous to `clk`
- `jshift`  in  1  `JSHIFT` from `JTAGG`; high in Shift-DR
- `jce1`, `jce2`  in  1 each  `JCE1`/`JCE2` from `JTAGG`
- `jrstn`  in  1  `JRSTN` from `JTAGG`; low means TAP reset
- `jtdo`  out  1  to `JTDO1` (`CHAIN`=1) or `JTDO2` (`CHAIN`=2)
- `tx_data`  in  32  word to send to the host
- `tx_valid`  in  1  `tx_data` is valid
- `tx_ready`  out  1  holding register is empty
- `tx_consumed`  out  1  one-cycle pulse when a held word is captured into the shift register

## Operation
- **TCK synchronizer:** a 3-flop chain `tck_s[2:0]` samples `jtck`.
  - `tck_rise` = (`tck_s[2:1]` == 2'b01).
  - `tck_fall` = (`tck_s[2:1]` == 2'b10).
  - `jshift`, `jce1` and `jce2` are sampled on the same `clk` cycle as the detected edge. They are stable around TCK edges, so they need no separate synchronizer.
- **Holding register:** `hold[31:0]` plus a `full` flag.
  - `tx_ready` = !`full`.
  - A transfer happens when `tx_valid && tx_ready`: `hold` takes `tx_data` and `full` goes to 1.
  - Data accepted while `full` is not possible, because `tx_ready` is low.
- **Capture:** on `tck_rise` with the selected `jce` high and `jshift` low (Capture-DR):
  - If `full`: `sreg` takes `hold`, `full` goes to 0, and `tx_consumed` pulses.
  - If not `full`: `sreg` takes 0.
- **Shift:** on `tck_fall` with `jshift` high and the selected `jce` high:
  - `sreg` shifts right by one and 0 enters the MSB.
  - After 32 shifts, `jtdo` outputs 0 for every further bit.
- **Output:** `jtdo` = `sreg[0]`. It is registered, so it changes only after `tck_fall` or after capture.
- **Other chain:** activity on the non-selected chain (its `jce`) is ignored.
- **Simultaneous events:**
  - Capture and a `tx_valid` transfer in the same cycle while empty: the capture loads 0, and the new word lands in `hold`.
  - Capture while `full`, with `tx_valid` high: `tx_ready` is still 0 that cycle, so the accept happens in the next cycle.
- **TAP reset:** `jrstn` low synchronously clears `sreg` and the shift counter. It does not touch `hold` or `full`, so a pending word survives a TAP reset.
- **Reset (`rst`):**
  - `sreg`, `hold`, `full`, `tck_s` all 0.
  - Outputs: `jtdo`=0, `tx_ready`=1, `tx_consumed`=0.
  - Reset asserted mid-shift aborts the transfer, and the host reads zeros.

## Timing
- Edge detection lags the TCK edge by 2–3 `clk` cycles.
- TCK high and low times must each be at least 4 `clk` periods. At 48 MHz this limits TCK to 6 MHz or less.
- `jtdo` is valid at most 4 `clk` after TCK falls, which is before the next TCK rise, where the host samples.
- `tx_consumed` is high in the same cycle `full` clears.
- `tx_ready` rises one cycle after capture.

## Configuration
- **`JTAG_TX_STATUS_EN` defined:**
  - The shift register is 33 bits.
  - Bit 0 is the valid flag: 1 when the capture consumed a held word, 0 when it was empty.
  - Data follows in bits 32:1, so the host shifts 33 bits and rejects words with the valid bit at 0.
- **`JTAG_TX_STATUS_EN` undefined:**
  - 32-bit shift register.
  - An empty capture is indistinguishable from a real word of 0x00000000.

## Structure
- Shared package `jtag_dr_pkg`:
  - `JTAG_DR_W` = 32.
  - `JTAG_TCK_SYNC_DEPTH` = 3.
  - Shift register width, derived from `JTAG_DR_W` and `JTAG_TX_STATUS_EN`.
  - `CHAIN` encoding constants.
- Sub-module `jtag_tck_sync`: synchronizer plus rise/fall edge detection. The existing JTAG receiver can reuse it.

## Test plan
- **Reset:** assert `rst` mid-simulation → `jtdo`=0, `tx_ready`=1, `full`=0 immediately (asynchronous).
- **Basic read:** send `tx_data`=0xDEADBEEF with `tx_valid`, then run Capture-DR plus 32 Shift-DR TCK cycles at 4 MHz → host samples 0xDEADBEEF LSB-first, `tx_consumed` pulses once, `tx_ready` goes back to 1.
- **Empty capture:** capture with `full`=0 → 32 zero bits. With `JTAG_TX_STATUS_EN`, 33 bits with bit0=0.
- **Same-cycle collision:** capture in the same cycle as accepting 0x12345678 → first scan reads 0, second scan reads 0x12345678.
- **TAP reset mid-shift:** `jrstn` low after 10 shifts of 0xA5A5A5A5 → `sreg` cleared, `full` unchanged, and the next capture of a new word 0x00000001 reads correctly.
- **Wrong chain:** `CHAIN`=1 with only `jce2` active during a capture and 32 shifts → `hold` is untouched and `jtdo` stays 0.

Source files
------------

// File: rtl/jtag_dr_pkg.sv
// Shared constants for the JTAG debug-register link (receiver and transmitter).
// JTAG_TX_STATUS_EN widens the TX shift register with a leading valid bit.
package jtag_dr_pkg;
  localparam int JTAG_DR_W           = 32;
  localparam int JTAG_TCK_SYNC_DEPTH = 3;

`ifdef JTAG_TX_STATUS_EN
  localparam int JTAG_SREG_W = JTAG_DR_W + 1;
`else
  localparam int JTAG_SREG_W = JTAG_DR_W;
`endif

  localparam int JTAG_CNT_W = $clog2(JTAG_SREG_W + 1);
  localparam logic [JTAG_CNT_W-1:0] JTAG_SREG_CNT = JTAG_CNT_W'(JTAG_SREG_W);

  // JTAGG user chain selection and the matching ER1/ER2 instruction codes
  localparam int         JTAG_CHAIN_1  = 1;
  localparam int         JTAG_CHAIN_2  = 2;
  localparam logic [7:0] JTAG_IR_CHAIN1 = 8'h32;
  localparam logic [7:0] JTAG_IR_CHAIN2 = 8'h38;
endpackage

// File: rtl/jtag_tck_sync.sv
// Oversamples raw JTCK into the clk domain and flags its rising/falling edges.
module jtag_tck_sync
  import jtag_dr_pkg::*;
#(
  parameter int DEPTH = JTAG_TCK_SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic jtck,
  output logic tck_rise,
  output logic tck_fall
);
  logic [DEPTH-1:0] tck_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tck_s <= '0;
    else     tck_s <= {tck_s[DEPTH-2:0], jtck};
  end

  // oldest two stages: [DEPTH-1] is the earlier sample
  assign tck_rise = (tck_s[DEPTH-1:DEPTH-2] == 2'b01);
  assign tck_fall = (tck_s[DEPTH-1:DEPTH-2] == 2'b10);
endmodule

// File: rtl/jtag_dr_tx.sv
// JTAG DR transmit path: one-entry holding register, captured at Capture-DR and
// shifted LSB-first onto JTDO1/JTDO2. Optional JTAG_TX_STATUS_EN adds a valid bit at bit 0.
module jtag_dr_tx
  import jtag_dr_pkg::*;
#(
  parameter int CHAIN = JTAG_CHAIN_1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jtck,
  input  logic                 jshift,
  input  logic                 jce1,
  input  logic                 jce2,
  input  logic                 jrstn,
  output logic                 jtdo,
  input  logic [JTAG_DR_W-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_consumed
);
  logic                   tck_rise, tck_fall;
  logic                   sel_jce, capture, shift;
  logic [JTAG_DR_W-1:0]   hold;
  logic                   full;
  logic [JTAG_SREG_W-1:0] sreg;
  logic [JTAG_SREG_W-1:0] cap_word;
  logic [JTAG_CNT_W-1:0]  cnt;

  jtag_tck_sync u_tck_sync (
    .clk      (clk),
    .rst      (rst),
    .jtck     (jtck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  assign sel_jce  = (CHAIN == JTAG_CHAIN_2) ? jce2 : jce1;
  assign capture  = tck_rise && sel_jce && !jshift;
  assign shift    = tck_fall && sel_jce && jshift;
  assign tx_ready = !full;
  assign jtdo     = sreg[0];

`ifdef JTAG_TX_STATUS_EN
  assign cap_word = {hold, 1'b1};
`else
  assign cap_word = hold;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg        <= '0;
      cnt         <= '0;
      hold        <= '0;
      full        <= 1'b0;
      tx_consumed <= 1'b0;
    end else begin
      tx_consumed <= 1'b0;
      // TAP reset only drops the scan in progress; a pending word stays held
      if (!jrstn) begin
        sreg <= '0;
        cnt  <= '0;
      end else if (capture) begin
        cnt <= '0;
        if (full) begin
          sreg        <= cap_word;
          full        <= 1'b0;
          tx_consumed <= 1'b1;
        end else begin
          sreg <= '0;
        end
      end else if (shift) begin
        if (cnt < JTAG_SREG_CNT) begin
          sreg <= {1'b0, sreg[JTAG_SREG_W-1:1]};
          cnt  <= cnt + 1'b1;
        end else begin
          sreg <= '0;
        end
      end
      // full was low here, so this never collides with the capture clearing it
      if (tx_valid && !full) begin
        hold <= tx_data;
        full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jtag_dr_tx.sv
// Scoreboard bench for jtag_dr_tx: a host task scans DR words, a monitor checks them.
module tb_jtag_dr_tx;
  import jtag_dr_pkg::*;

  localparam int SW = JTAG_SREG_W;

  logic        clk = 1'b0, rst = 1'b1;
  logic        jtck = 1'b0, jshift = 1'b0, jce1 = 1'b0, jce2 = 1'b0, jrstn = 1'b1;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        jtdo, tx_ready, tx_consumed;

  int          n_chk = 0, n_fail = 0, n_cons = 0, exp_cons = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_word = '0;
  logic        scan_done = 1'b0;

  jtag_dr_tx #(.CHAIN(1)) dut (
    .clk(clk), .rst(rst), .jtck(jtck), .jshift(jshift), .jce1(jce1), .jce2(jce2),
    .jrstn(jrstn), .jtdo(jtdo), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_consumed(tx_consumed)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_scan(logic [31:0] d, logic v, int n);
    logic [63:0] w;
`ifdef JTAG_TX_STATUS_EN
    w = {31'b0, d, v};
`else
    w = v ? {32'b0, d} : 64'd0;
`endif
    return w & ((64'd1 << n) - 64'd1);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clk_n(int n);
    repeat (n) @(negedge clk);
  endtask

  // offer a word until the DUT takes it (bounded)
  task automatic send(logic [31:0] d);
    bit acc = 0;
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = tx_ready;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    if (!acc) begin n_chk++; n_fail++; $display("FAIL send_timeout: got no accept, required accept"); end
  endtask

  // Capture-DR then nbits Shift-DR cycles; optionally offer a word right at the capture edge
  task automatic scan(int nbits, bit chain2, bit inject, logic [31:0] inj_d);
    logic [63:0] w = '0;
    bit acc = 0;
    @(negedge clk);
    jce1 = !chain2; jce2 = chain2; jshift = 1'b0; jtck = 1'b1;
    if (inject) begin
      @(posedge clk); @(posedge clk); #1;
      tx_data = inj_d; tx_valid = 1'b1;
      for (int k = 0; k < 20 && !acc; k++) begin
        acc = tx_ready;
        @(posedge clk); #1;
      end
      tx_valid = 1'b0;
      if (!acc) begin n_chk++; n_fail++; $display("FAIL inject_timeout: got no accept, required accept"); end
    end
    clk_n(6); jtck = 1'b0; clk_n(6);
    for (int i = 0; i < nbits; i++) begin
      w[i] = jtdo;
      jshift = 1'b1; jtck = 1'b1; clk_n(6);
      jtck = 1'b0; clk_n(6);
    end
    jshift = 1'b0; jce1 = 1'b0; jce2 = 1'b0;
    got_word = w; scan_done = 1'b1;
    @(negedge clk); scan_done = 1'b0;
  endtask

  always @(posedge clk) begin
    if (scan_done) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scan_unexpected: got %h with no expected word", got_word);
      end else chk("scan_word", got_word, exp_q.pop_front());
    end
  end

  always @(negedge clk) if (tx_consumed) n_cons++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clk_n(4);
    chk("rst_jtdo", jtdo, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_consumed", tx_consumed, 0);
    rst = 1'b0;
    clk_n(2);

    // basic read
    send(32'hDEADBEEF);
    chk("ready_low_when_full", tx_ready, 0);
    exp_q.push_back(exp_scan(32'hDEADBEEF, 1, SW)); exp_cons++;
    scan(SW, 0, 0, 0);
    chk("ready_after_capture", tx_ready, 1);
    chk("consumed_basic", n_cons, exp_cons);

    // empty capture
    exp_q.push_back(exp_scan(0, 0, SW));
    scan(SW, 0, 0, 0);
    chk("consumed_empty", n_cons, exp_cons);

    // capture and accept in the same cycle
    exp_q.push_back(exp_scan(0, 0, SW));
    scan(SW, 0, 1, 32'h12345678);
    chk("collision_held", tx_ready, 0);
    exp_q.push_back(exp_scan(32'h12345678, 1, SW)); exp_cons++;
    scan(SW, 0, 0, 0);
    chk("consumed_collision", n_cons, exp_cons);

    // capture while full with a new word waiting: accepted the cycle after
    send(32'h11112222);
    exp_q.push_back(exp_scan(32'h11112222, 1, SW)); exp_cons++;
    scan(SW, 0, 1, 32'h33334444);
    chk("full_inject_held", tx_ready, 0);
    exp_q.push_back(exp_scan(32'h33334444, 1, SW)); exp_cons++;
    scan(SW, 0, 0, 0);
    chk("consumed_full_inject", n_cons, exp_cons);

    // TAP reset after 10 shifts; pending word survives
    send(32'hA5A5A5A5);
    exp_q.push_back(exp_scan(32'hA5A5A5A5, 1, 10)); exp_cons++;
    scan(10, 0, 0, 0);
    send(32'h00000001);
    @(negedge clk); jrstn = 1'b0;
    clk_n(3);
    chk("taprst_jtdo", jtdo, 0);
    jrstn = 1'b1;
    chk("taprst_full_kept", tx_ready, 0);
    exp_q.push_back(exp_scan(32'h00000001, 1, SW)); exp_cons++;
    scan(SW, 0, 0, 0);

    // wrong chain ignored
    send(32'hCAFEF00D);
    exp_q.push_back(64'd0);
    scan(SW, 1, 0, 0);
    chk("wrong_chain_hold", tx_ready, 0);
    chk("wrong_chain_consumed", n_cons, exp_cons);
    exp_q.push_back(exp_scan(32'hCAFEF00D, 1, SW)); exp_cons++;
    scan(SW, 0, 0, 0);

    // asynchronous reset mid-shift with a word pending
    send(32'hFFFFFFFF);
    exp_q.push_back(exp_scan(32'hFFFFFFFF, 1, 4)); exp_cons++;
    scan(4, 0, 0, 0);
    send(32'h0BADF00D);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_jtdo", jtdo, 0);
    chk("async_rst_ready", tx_ready, 1);
    @(negedge clk); rst = 1'b0;
    exp_q.push_back(exp_scan(0, 0, SW));
    scan(SW, 0, 0, 0);
    chk("consumed_final", n_cons, exp_cons);

    clk_n(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
